index_cursor_ctrl: RTL and testbench

//  Produces the cursor anchor (x_pin, y_pin) consumed by the hand-index highlight renderer.

---
 rtl/index_cursor_ctrl.sv | 150 +++++++++++++++
 tb/tb_index_cursor_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/index_cursor_ctrl.sv
// index_cursor_ctrl: debounced KEY-driven hand-slot cursor with a valid/ack select request.
// Define AUTO_REPEAT_EN to add hold-to-repeat on the left/right keys.
//
// state    | meaning
// IDLE     | cursor follows left/right presses, select press raises a request
// WAIT_ACK | request pending, cursor frozen and lifted until sel_ack
module index_cursor_ctrl #(
  parameter int X_BASE     = 40,
  parameter int Y_BASE     = 400,
  parameter int SLOT_PITCH = 40,
  parameter int Y_LIFT     = 12,
  parameter int MAX_SLOTS  = 15,
  parameter int DEB_CYCLES = 500000,
  parameter int RPT_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       key_sel_n,
  input  logic [4:0] hand_count,
  input  logic       frame_tick,
  input  logic       sel_ack,
  output logic [9:0] x_pin,
  output logic [9:0] y_pin,
  output logic [4:0] sel_idx,
  output logic       sel_valid
);

  typedef enum logic [0:0] {IDLE, WAIT_ACK} state_t;

  localparam int DW = $clog2(DEB_CYCLES + 1);

  state_t      state, state_nxt;
  logic [4:0]  idx_nxt;
  logic [4:0]  hc;
  logic [2:0]  sync1, sync2, deb, deb_q, press;
  logic [DW-1:0] deb_cnt [3];
  logic [1:0]  move;
  logic        go_left, go_right;
  logic [9:0]  target_x, target_y;

  // Key bit order: 0 = left, 1 = right, 2 = select; all active-high after sync1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
    end else begin
      sync1 <= ~{key_sel_n, key_right_n, key_left_n};
      sync2 <= sync1;
      deb_q <= deb;
      for (int k = 0; k < 3; k++) begin
        if (sync2[k] == deb[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DW'(DEB_CYCLES - 1)) begin
          deb[k]     <= sync2[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(RPT_CYCLES + 1);

  logic [RW-1:0] rpt_cnt [2];
  logic [1:0]    rpt_hold, rpt_fire;

  always_comb begin
    rpt_hold = '0;
    rpt_fire = '0;
    for (int k = 0; k < 2; k++) begin
      rpt_hold[k] = deb[k] && !(deb[0] && deb[1]) && (state == IDLE);
      rpt_fire[k] = rpt_hold[k] && (rpt_cnt[k] == RW'(RPT_CYCLES));
    end
  end

  // Counter holds cycles since the press; a fire restarts it at 1 so steps stay RPT_CYCLES apart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) rpt_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!rpt_hold[k])     rpt_cnt[k] <= '0;
        else if (rpt_fire[k]) rpt_cnt[k] <= RW'(1);
        else                  rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
      end
    end
  end

  assign move = press[1:0] | rpt_fire;
`else
  assign move = press[1:0];
`endif

  assign hc = (hand_count > 5'(MAX_SLOTS)) ? 5'(MAX_SLOTS) : hand_count;

  always_comb begin
    state_nxt = state;
    idx_nxt   = sel_idx;
    go_left   = move[0] & ~move[1];
    go_right  = move[1] & ~move[0];
    case (state)
      IDLE: begin
        if (press[2] && hc != '0) begin
          state_nxt = WAIT_ACK;
        end else if (go_left && sel_idx != '0) begin
          idx_nxt = sel_idx - 5'd1;
        end else if (go_right && (({1'b0, sel_idx} + 6'd1) < {1'b0, hc})) begin
          idx_nxt = sel_idx + 5'd1;
        end
      end
      WAIT_ACK: begin
        if (sel_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Shrinking hand pulls the cursor back in range in either state.
    if (hc == '0)          idx_nxt = '0;
    else if (idx_nxt >= hc) idx_nxt = hc - 5'd1;
  end

  assign target_x  = 10'(X_BASE) + 10'(sel_idx) * 10'(SLOT_PITCH);
  assign target_y  = (state == WAIT_ACK) ? 10'(Y_BASE - Y_LIFT) : 10'(Y_BASE);
  assign sel_valid = (state == WAIT_ACK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_idx <= '0;
      x_pin   <= 10'(X_BASE);
      y_pin   <= 10'(Y_BASE);
    end else begin
      state   <= state_nxt;
      sel_idx <= idx_nxt;
      if (frame_tick) begin
        x_pin <= target_x;
        y_pin <= target_y;
      end
    end
  end

endmodule

// File: tb/tb_index_cursor_ctrl.sv
// tb_index_cursor_ctrl: directed scenarios plus random key/hand/ack traffic against a cycle model.
// Honours AUTO_REPEAT_EN the same way as the design.
module tb_index_cursor_ctrl;
  localparam int DEB = 4;
  localparam int RPT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic [4:0] hand_count = '0;
  logic       frame_tick = 1'b0;
  logic       sel_ack = 1'b0;
  logic [9:0] x_pin, y_pin;
  logic [4:0] sel_idx;
  logic       sel_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  bit chk_on  = 1'b0;

  index_cursor_ctrl #(.DEB_CYCLES(DEB), .RPT_CYCLES(RPT)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_left_n(key_n[0]), .key_right_n(key_n[1]), .key_sel_n(key_n[2]),
    .hand_count(hand_count), .frame_tick(frame_tick), .sel_ack(sel_ack),
    .x_pin(x_pin), .y_pin(y_pin), .sel_idx(sel_idx), .sel_valid(sel_valid)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    cyc_cnt++;
    frame_tick = (cyc_cnt % 50 == 49);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: keys seen two cycles late, a level flips after DEB differing cycles,
  // repeats fire at every multiple of RPT held cycles after the press.
  bit m_s1[3], m_s2[3], m_deb[3], m_debq[3];
  int m_dc[3];
  int m_rc[2];
  bit m_wait;
  int m_idx, m_x, m_y;

  always @(posedge clk) begin
    bit ev[3];
    bit fire[2];
    bit held, l, r;
    int hc;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_deb[k] = 0; m_debq[k] = 0; m_dc[k] = 0;
      end
      m_rc[0] = 0; m_rc[1] = 0;
      m_wait = 0; m_idx = 0; m_x = 40; m_y = 400;
    end else begin
      hc = int'(hand_count);
      for (int k = 0; k < 3; k++) ev[k] = m_deb[k] && !m_debq[k];
      for (int k = 0; k < 2; k++) begin
        held = m_deb[k] && !m_wait && !(m_deb[0] && m_deb[1]);
`ifdef AUTO_REPEAT_EN
        fire[k] = held && m_rc[k] > 0 && (m_rc[k] % RPT == 0);
`else
        fire[k] = 0;
`endif
        m_rc[k] = held ? m_rc[k] + 1 : 0;
      end
      if (frame_tick) begin
        m_x = 40 + m_idx * 40;
        m_y = m_wait ? 388 : 400;
      end
      l = ev[0] || fire[0];
      r = ev[1] || fire[1];
      if (!m_wait) begin
        if (ev[2] && hc != 0)             m_wait = 1;
        else if (l && !r)                 m_idx = (m_idx > 0) ? m_idx - 1 : 0;
        else if (r && !l && m_idx < hc-1) m_idx = m_idx + 1;
      end else if (sel_ack) begin
        m_wait = 0;
      end
      if (hc == 0)         m_idx = 0;
      else if (m_idx >= hc) m_idx = hc - 1;
      for (int k = 0; k < 3; k++) begin
        m_debq[k] = m_deb[k];
        if (m_s2[k] != m_deb[k]) begin
          m_dc[k]++;
          if (m_dc[k] == DEB) begin
            m_deb[k] = !m_deb[k];
            m_dc[k] = 0;
          end
        end else begin
          m_dc[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = !key_n[k];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_x", int'(x_pin), m_x);
      chk("model_y", int'(y_pin), m_y);
      chk("model_idx", int'(sel_idx), m_idx);
      chk("model_valid", int'(sel_valid), int'(m_wait));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int lo, input int hi);
    key_n[k] = 1'b0;
    cyc(lo);
    key_n[k] = 1'b1;
    cyc(hi);
  endtask

  initial begin
    int exp_rpt;
    rst_n = 1'b0;
    cyc(2);
    chk("rst_x", int'(x_pin), 40);
    chk("rst_y", int'(y_pin), 400);
    chk("rst_idx", int'(sel_idx), 0);
    chk("rst_valid", int'(sel_valid), 0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    hand_count = 5'd5;
    press(1, 3, 1);
    press(1, 10, 10);
    chk("deb_idx", int'(sel_idx), 1);
    cyc(52);
    chk("deb_x", int'(x_pin), 80);

    hand_count = 5'd3;
    for (int i = 0; i < 5; i++) press(1, 8, 10);
    chk("clamp_idx", int'(sel_idx), 2);
    hand_count = 5'd1;
    cyc(1);
    chk("shrink_idx", int'(sel_idx), 0);

    hand_count = 5'd4;
    press(1, 8, 10);
    press(1, 8, 10);
    chk("hs_idx", int'(sel_idx), 2);
    press(2, 8, 10);
    chk("hs_valid", int'(sel_valid), 1);
    cyc(52);
    chk("hs_lift_y", int'(y_pin), 388);
    press(1, 8, 10);
    chk("hs_frozen_idx", int'(sel_idx), 2);
    sel_ack = 1'b1;
    cyc(1);
    sel_ack = 1'b0;
    chk("hs_ack_valid", int'(sel_valid), 0);
    cyc(52);
    chk("hs_rest_y", int'(y_pin), 400);

    hand_count = 5'd0;
    press(2, 8, 10);
    chk("empty_valid", int'(sel_valid), 0);
    chk("empty_idx", int'(sel_idx), 0);

    hand_count = 5'd15;
    press(1, 70, 12);
`ifdef AUTO_REPEAT_EN
    exp_rpt = 4;
`else
    exp_rpt = 1;
`endif
    chk("repeat_idx", int'(sel_idx), exp_rpt);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) key_n = 3'($urandom);
      else key_n = ~(3'b001 << $urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) hand_count = 5'($urandom_range(0, 15));
      sel_ack = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 25));
    end

    key_n = 3'b111;
    sel_ack = 1'b1;
    cyc(20);
    sel_ack = 1'b0;
    hand_count = 5'd3;
    press(2, 8, 10);
    chk("mid_hs_valid", int'(sel_valid), 1);
    rst_n = 1'b0;
    cyc(1);
    chk("rst_drop_valid", int'(sel_valid), 0);
    rst_n = 1'b1;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
